// File: rtl/l2_fwd_in_stage.sv
// l2_fwd_in_stage
// Forward-input stage of the L2 controller. Holds one forward message,
// issues a PEEK_FWD lookup into the request buffer, parks the message while
// the buffer reports a conflict and re-peeks when the blocking entry is
// written, then hands the message (with the captured hit flag and index)
// to the L2 main FSM.
//
// Optional feature: define L2_FWD_STALL_WATCHDOG_EN to build a stall
// watchdog that raises a sticky fwd_stall_timeout after STALL_TIMEOUT
// consecutive parked cycles. Without the macro, fwd_stall_timeout is 0.

module l2_fwd_in_stage #(
    parameter int REQS_BITS      = 2,
    parameter int LINE_ADDR_BITS = 28,
    parameter int MSG_BITS       = 3,
    parameter int REQ_ID_BITS    = 4,
    parameter int STALL_TIMEOUT  = 4096
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      fwd_in_valid,
    output logic                      fwd_in_ready,
    input  logic [MSG_BITS-1:0]       fwd_in_coh_msg,
    input  logic [LINE_ADDR_BITS-1:0] fwd_in_addr,
    input  logic [REQ_ID_BITS-1:0]    fwd_in_req_id,

    output logic                      peek_fwd,
    output logic [LINE_ADDR_BITS-1:0] peek_addr,
    input  logic                      set_fwd_stall,
    input  logic                      clr_fwd_stall,
    input  logic                      reqs_hit_next,
    input  logic [REQS_BITS-1:0]      reqs_i_next,
    input  logic                      reqs_update,
    input  logic [REQS_BITS-1:0]      reqs_update_i,

    output logic                      fwd_out_valid,
    input  logic                      fwd_out_ready,
    output logic [MSG_BITS-1:0]       fwd_out_coh_msg,
    output logic [LINE_ADDR_BITS-1:0] fwd_out_addr,
    output logic [REQ_ID_BITS-1:0]    fwd_out_req_id,
    output logic                      fwd_out_hit,
    output logic [REQS_BITS-1:0]      fwd_out_reqs_i,

    output logic                      fwd_stall,
    output logic [REQS_BITS-1:0]      fwd_stall_i,
    output logic                      fwd_stall_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEEK  = 2'd1,
        ST_STALL = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;

    logic [MSG_BITS-1:0]       msg_r;
    logic [LINE_ADDR_BITS-1:0] addr_r;
    logic [REQ_ID_BITS-1:0]    req_id_r;
    logic                      hit_r;
    logic [REQS_BITS-1:0]      reqs_i_r;
    logic [REQS_BITS-1:0]      stall_i_r;

    logic                      accept_s;
    logic                      capture_s;
    logic                      park_s;
    logic                      repeek_s;
    logic                      proceed_s;
    logic                      release_s;

    // A peek racing with a write to the very entry it reported is stale.
    assign repeek_s  = reqs_update && (reqs_update_i == reqs_i_next);
    // Only a clean "proceed" result leaves PEEK forward; anything else parks.
    assign proceed_s = clr_fwd_stall && !set_fwd_stall;
    // The parked message wakes only when its own blocking entry changes.
    assign release_s = reqs_update && (reqs_update_i == stall_i_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and datapath load strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        park_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fwd_in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_PEEK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PEEK: begin
                if (repeek_s) begin
                    state_next_s = ST_PEEK;
                end else if (proceed_s) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_ISSUE;
                end else begin
                    park_s       = 1'b1;
                    state_next_s = ST_STALL;
                end
            end
            ST_STALL: begin
                if (release_s) begin
                    state_next_s = ST_PEEK;
                end else begin
                    state_next_s = ST_STALL;
                end
            end
            ST_ISSUE: begin
                if (fwd_out_ready) begin
                    if (fwd_in_valid) begin
                        accept_s     = 1'b1;
                        state_next_s = ST_PEEK;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        fwd_in_ready  = 1'b0;
        peek_fwd      = 1'b0;
        peek_addr     = {LINE_ADDR_BITS{1'b0}};
        fwd_out_valid = 1'b0;
        fwd_stall     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                fwd_in_ready = 1'b1;
            end
            ST_PEEK: begin
                peek_fwd  = 1'b1;
                peek_addr = addr_r;
            end
            ST_STALL: begin
                fwd_stall = 1'b1;
            end
            ST_ISSUE: begin
                fwd_out_valid = 1'b1;
                // Consuming the current message frees the slot this cycle.
                fwd_in_ready  = fwd_out_ready;
            end
            default: begin
                fwd_in_ready = 1'b0;
            end
        endcase
    end

    // Held message: loaded on accept, otherwise stable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            msg_r    <= {MSG_BITS{1'b0}};
            addr_r   <= {LINE_ADDR_BITS{1'b0}};
            req_id_r <= {REQ_ID_BITS{1'b0}};
        end else if (accept_s) begin
            msg_r    <= fwd_in_coh_msg;
            addr_r   <= fwd_in_addr;
            req_id_r <= fwd_in_req_id;
        end else begin
            msg_r    <= msg_r;
            addr_r   <= addr_r;
            req_id_r <= req_id_r;
        end
    end

    // Hit flag and index captured from the final (proceeding) peek.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_r    <= 1'b0;
            reqs_i_r <= {REQS_BITS{1'b0}};
        end else if (capture_s) begin
            hit_r    <= reqs_hit_next;
            reqs_i_r <= reqs_i_next;
        end else begin
            hit_r    <= hit_r;
            reqs_i_r <= reqs_i_r;
        end
    end

    // Blocking entry index, loaded when the message is parked.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_i_r <= {REQS_BITS{1'b0}};
        end else if (park_s) begin
            stall_i_r <= reqs_i_next;
        end else begin
            stall_i_r <= stall_i_r;
        end
    end

    assign fwd_out_coh_msg = msg_r;
    assign fwd_out_addr    = addr_r;
    assign fwd_out_req_id  = req_id_r;
    assign fwd_out_hit     = hit_r;
    assign fwd_out_reqs_i  = reqs_i_r;
    assign fwd_stall_i     = stall_i_r;

`ifdef L2_FWD_STALL_WATCHDOG_EN
    localparam int CNT_W = $clog2(STALL_TIMEOUT) + 1;

    logic [CNT_W-1:0] stall_cnt_r;
    logic             timeout_r;

    // Consecutive parked-cycle counter, saturating at the threshold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_STALL) begin
            if (stall_cnt_r != CNT_W'(STALL_TIMEOUT)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end else begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Sticky flag, set on the same edge the counter reaches the threshold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_r <= 1'b0;
        end else if ((state_r == ST_STALL) &&
                     (stall_cnt_r == CNT_W'(STALL_TIMEOUT - 1))) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign fwd_stall_timeout = timeout_r;
`else
    // No watchdog built; the threshold term folds to a constant 0.
    assign fwd_stall_timeout = (STALL_TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

endmodule
